// File: rtl/metric_sequencer_pkg.sv
// Shared state encoding and default geometry for the path-metric sequencer,
// matched to the metric memory depth and survivor RAM width.
package metric_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_SWAP  = 2'd3
  } ms_state_e;

  localparam int N_ITER_DEF         = 64;
  localparam int WD_FSM_DEF         = 6;
  localparam int WD_RAM_ADDRESS_DEF = 11;

endpackage

// File: rtl/metric_sequencer_acs.sv
// acs_delay_line: (valid, address) shift register that aligns metric write
// strobes with the ACS pipeline result.
module acs_delay_line #(
  parameter int DEPTH = 1,
  parameter int W     = 6
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         in_valid,
  input  logic [W-1:0] in_addr,
  output logic         out_valid,
  output logic [W-1:0] out_addr
);

  logic [DEPTH-1:0] valid_q;
  logic [W-1:0]     addr_q [DEPTH];

  always_ff @(posedge clk) begin
    if (clr) begin
      valid_q <= '0;
      for (int k = 0; k < DEPTH; k++) addr_q[k] <= '0;
    end else begin
      valid_q[0] <= in_valid;
      addr_q[0]  <= in_addr;
      for (int k = 1; k < DEPTH; k++) begin
        valid_q[k] <= valid_q[k-1];
        addr_q[k]  <= addr_q[k-1];
      end
    end
  end

  assign out_valid = valid_q[DEPTH-1];
  assign out_addr  = addr_q[DEPTH-1];

endmodule

// File: rtl/metric_sequencer.sv
// Per-symbol trellis pass sequencer: predecessor-pair reads, delayed metric
// writes, A/B block swap, survivor row pointer and traceback trigger.
module metric_sequencer
  import metric_sequencer_pkg::*;
#(
  parameter int N_ITER         = N_ITER_DEF,
  parameter int WD_FSM         = WD_FSM_DEF,
  parameter int ACS_LAT        = 1,
  parameter int WD_RAM_ADDRESS = WD_RAM_ADDRESS_DEF,
  parameter int TB_LEN         = 32
) (
  input  logic                      Clock1,
  input  logic                      Reset,
  input  logic                      SymValid,
  output logic                      SymReady,
  output logic [WD_FSM-2:0]         MMReadAddress,
  output logic [WD_FSM-1:0]         MMWriteAddress,
  output logic                      Active,
  output logic                      MMBlockSelect,
  output logic [WD_RAM_ADDRESS-1:0] SurvivorAddress,
  output logic                      SymbolDone,
  output logic                      TracebackStart,
  output logic [1:0]                DebugState
);

  localparam int SYM_W = $clog2(TB_LEN);

  // Handshake: a symbol is accepted on the rising edge where SymValid and
  // SymReady are both high; SymValid is ignored whenever SymReady is low.
  ms_state_e             state_q, state_d;
  logic [WD_FSM-1:0]     cnt_q;
  logic [WD_FSM-1:0]     cnt_inc;
  logic [WD_FSM-2:0]     rd_addr_q;
  logic                  sym_ready_q;
  logic                  sym_done_q;
  logic                  tb_start_q;
  logic                  blk_sel_q;
  logic [WD_RAM_ADDRESS-1:0] surv_q;
  logic [SYM_W-1:0]      sym_cnt_q;
  logic                  dl_valid;
  logic [WD_FSM-1:0]     dl_addr;

  assign cnt_inc = cnt_q + 1'b1;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (SymValid) state_d = ST_RUN;
      ST_RUN:   if (cnt_q == WD_FSM'(N_ITER - 1)) state_d = ST_DRAIN;
      ST_DRAIN: if (cnt_q == WD_FSM'(ACS_LAT - 1)) state_d = ST_SWAP;
      ST_SWAP:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clock1) begin
    if (Reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      rd_addr_q   <= '0;
      sym_ready_q <= 1'b1;
      sym_done_q  <= 1'b0;
      tb_start_q  <= 1'b0;
      blk_sel_q   <= 1'b0;
      surv_q      <= '0;
      sym_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      sym_ready_q <= (state_d == ST_IDLE);
      sym_done_q  <= (state_d == ST_SWAP);
      tb_start_q  <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (state_d == ST_RUN) begin
            cnt_q     <= '0;
            rd_addr_q <= '0;
          end
        end
        ST_RUN: begin
          if (state_d == ST_DRAIN) begin
            cnt_q <= '0;
          end else begin
            cnt_q     <= cnt_inc;
            // States s and s+N/2 share predecessor pair s mod N/2.
            rd_addr_q <= cnt_inc[WD_FSM-2:0];
          end
        end
        ST_DRAIN: begin
          cnt_q <= cnt_inc;
          if (state_d == ST_SWAP) begin
            blk_sel_q <= ~blk_sel_q;
            surv_q    <= surv_q + 1'b1;
            if (sym_cnt_q == SYM_W'(TB_LEN - 1)) begin
              sym_cnt_q  <= '0;
              tb_start_q <= 1'b1;
            end else begin
              sym_cnt_q <= sym_cnt_q + 1'b1;
            end
          end
        end
        ST_SWAP: cnt_q <= '0;
        default: cnt_q <= '0;
      endcase
    end
  end

  // The delay line taps the read currently being issued, so each write lands
  // exactly ACS_LAT cycles after its read address.
  acs_delay_line #(
    .DEPTH (ACS_LAT),
    .W     (WD_FSM)
  ) u_acs_delay (
    .clk       (Clock1),
    .clr       (Reset),
    .in_valid  (state_q == ST_RUN),
    .in_addr   (cnt_q),
    .out_valid (dl_valid),
    .out_addr  (dl_addr)
  );

  assign SymReady        = sym_ready_q;
  assign MMReadAddress   = rd_addr_q;
  assign MMWriteAddress  = dl_addr;
  assign Active          = dl_valid;
  assign MMBlockSelect   = blk_sel_q;
  assign SurvivorAddress = surv_q;
  assign SymbolDone      = sym_done_q;
  assign TracebackStart  = tb_start_q;
  assign DebugState      = state_q;

endmodule
